// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS instruction/data bus arbiter.
// Holds the arbiter state encoding, the full-word byte-enable pattern
// and the encodings driven on the grant observability port.
package mips_bus_pkg;

    // Arbiter state: which requester currently owns the memory port.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_FETCH = 2'b01,
        ARB_DATA  = 2'b10
    } arb_state_t;

    // Byte enables for a full 32-bit word; instruction fetch always reads a full word.
    localparam logic [3:0] BE_ALL = 4'b1111;

    // Values presented on the grant port.
    localparam logic [1:0] GRANT_IDLE  = 2'b00;
    localparam logic [1:0] GRANT_FETCH = 2'b01;
    localparam logic [1:0] GRANT_DATA  = 2'b10;

endpackage

// File: rtl/mips_bus_arbiter.sv
// Two-requester arbiter sharing one Avalon-style RAM port between fetch and data.
// Latency: 1 cycle from a request seen in idle to the memory side; handover bubble-free.
// Backpressure: granted requester sees m_waitrequest, the other (and both in idle) see 1.
//
// Ports:
//   clk, reset                   clock and synchronous active-high reset
//   f_*                          fetch requester (read-only)
//   d_*                          data requester (load/store)
//   m_*                          memory-side master port
//   grant                        observability: 00 idle, 01 fetch, 10 data
import mips_bus_pkg::*;

module mips_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     f_address,
    input  logic                  f_read,
    output logic                  f_waitrequest,
    output logic [DATA_W-1:0]     f_readdata,

    input  logic [ADDR_W-1:0]     d_address,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [DATA_W-1:0]     d_writedata,
    input  logic [DATA_W/8-1:0]   d_byteenable,
    output logic                  d_waitrequest,
    output logic [DATA_W-1:0]     d_readdata,

    output logic [ADDR_W-1:0]     m_address,
    output logic                  m_read,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata,
    output logic [DATA_W/8-1:0]   m_byteenable,
    input  logic                  m_waitrequest,
    input  logic [DATA_W-1:0]     m_readdata,

    output logic [1:0]            grant
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t state_q, state_d;
    // 0 = fetch completed last, 1 = data completed last; the other side wins ties.
    logic       last_grant_q, last_grant_d;

    logic f_req;
    logic d_req;

    assign f_req = f_read;
    assign d_req = d_read | d_write;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                // m_waitrequest is irrelevant here: nothing is on the bus.
                if (f_req && d_req) begin
                    state_d = last_grant_q ? ARB_FETCH : ARB_DATA;
                end else if (f_req) begin
                    state_d = ARB_FETCH;
                end else if (d_req) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_FETCH: begin
                if (!f_req) begin
                    // Request withdrawn mid-transfer: abandon without crediting it.
                    state_d = ARB_IDLE;
                end else if (!m_waitrequest) begin
                    last_grant_d = 1'b0;
                    state_d      = d_req ? ARB_DATA : ARB_IDLE;
                end
            end
            ARB_DATA: begin
                if (!d_req) begin
                    state_d = ARB_IDLE;
                end else if (!m_waitrequest) begin
                    last_grant_d = 1'b1;
                    state_d      = f_req ? ARB_FETCH : ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // ------------------------------------------------------------------
    // Output mux, driven from the registered owner only. Requester
    // address/data are forwarded live, so requesters must hold them
    // stable until their transfer completes.
    // ------------------------------------------------------------------
    always_comb begin
        m_address     = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;
        m_byteenable  = '0;
        f_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        grant         = GRANT_IDLE;
        case (state_q)
            ARB_FETCH: begin
                m_address     = f_address;
                m_read        = f_read;
                m_byteenable  = {BE_W{1'b1}};
                f_waitrequest = m_waitrequest;
                grant         = GRANT_FETCH;
            end
            ARB_DATA: begin
                m_address     = d_address;
                // A simultaneous read and write is resolved in favour of the write.
                m_read        = d_read & ~d_write;
                m_write       = d_write;
                m_writedata   = d_writedata;
                m_byteenable  = d_byteenable;
                d_waitrequest = m_waitrequest;
                grant         = GRANT_DATA;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; only the granted requester's completion cycle is meaningful.
    assign f_readdata = m_readdata;
    assign d_readdata = m_readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed self-checking bench for mips_bus_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every expected value below is hand-derived from the arbiter's documented behaviour.
import mips_bus_pkg::*;

module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_address;
    logic        f_read;
    logic        f_waitrequest;
    logic [31:0] f_readdata;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .f_address     (f_address),
        .f_read        (f_read),
        .f_waitrequest (f_waitrequest),
        .f_readdata    (f_readdata),
        .d_address     (d_address),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_writedata   (d_writedata),
        .d_byteenable  (d_byteenable),
        .d_waitrequest (d_waitrequest),
        .d_readdata    (d_readdata),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_byteenable  (m_byteenable),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .grant         (grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge so inputs can be changed safely.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        f_address     = '0;
        f_read        = 1'b0;
        d_address     = '0;
        d_read        = 1'b0;
        d_write       = 1'b0;
        d_writedata   = '0;
        d_byteenable  = '0;
        m_waitrequest = 1'b0;
        m_readdata    = '0;

        // ---------------- reset and idle ----------------
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("idle_m_read",  m_read,        1'b0);
            chk("idle_m_write", m_write,       1'b0);
            chk("idle_f_wait",  f_waitrequest, 1'b1);
            chk("idle_d_wait",  d_waitrequest, 1'b1);
            chk("idle_grant",   grant,         2'b00);
            chk("idle_m_addr",  m_address,     32'h0);
            chk("idle_m_be",    m_byteenable,  4'h0);
            tick();
        end

        // ---------------- single fetch, no wait ----------------
        f_read     = 1'b1;
        f_address  = 32'hBFC0_0000;
        m_readdata = 32'h1234_5678;
        sample();
        chk("f1_req_cycle_grant", grant,         2'b00);
        chk("f1_req_cycle_fwait", f_waitrequest, 1'b1);
        tick();
        sample();
        chk("f1_grant",    grant,         2'b01);
        chk("f1_m_addr",   m_address,     32'hBFC0_0000);
        chk("f1_m_read",   m_read,        1'b1);
        chk("f1_m_write",  m_write,       1'b0);
        chk("f1_m_be",     m_byteenable,  BE_ALL);
        chk("f1_m_wdata",  m_writedata,   32'h0);
        chk("f1_f_wait",   f_waitrequest, 1'b0);
        chk("f1_d_wait",   d_waitrequest, 1'b1);
        chk("f1_rdata",    f_readdata,    32'h1234_5678);
        tick();
        f_read = 1'b0;
        sample();
        chk("f1_after_grant",  grant,  2'b00);
        chk("f1_after_m_read", m_read, 1'b0);

        // ---------------- tie after reset: fetch first, then data ----------------
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        f_read       = 1'b1;
        f_address    = 32'h0000_0100;
        d_write      = 1'b1;
        d_address    = 32'h0000_0004;
        d_writedata  = 32'hDEAD_BEEF;
        d_byteenable = 4'b0011;
        sample();
        chk("tie_req_grant", grant, 2'b00);
        tick();
        sample();
        chk("tie_first_grant", grant,         2'b01);
        chk("tie_first_fwait", f_waitrequest, 1'b0);
        chk("tie_first_dwait", d_waitrequest, 1'b1);
        chk("tie_first_mwr",   m_write,       1'b0);
        tick();
        f_read = 1'b0;
        sample();
        chk("tie_hand_grant", grant,         2'b10);
        chk("tie_hand_mwr",   m_write,       1'b1);
        chk("tie_hand_mrd",   m_read,        1'b0);
        chk("tie_hand_addr",  m_address,     32'h0000_0004);
        chk("tie_hand_wdata", m_writedata,   32'hDEAD_BEEF);
        chk("tie_hand_be",    m_byteenable,  4'b0011);
        chk("tie_hand_dwait", d_waitrequest, 1'b0);
        tick();
        d_write = 1'b0;
        sample();
        chk("tie_done_grant", grant, 2'b00);

        // ---------------- data read stalled 4 cycles, fetch waiting ----------------
        d_read        = 1'b1;
        d_address     = 32'h0000_0200;
        d_byteenable  = 4'b1111;
        m_waitrequest = 1'b1;
        tick();
        f_read    = 1'b1;
        f_address = 32'h0000_0300;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("stall_grant", grant,         2'b10);
            chk("stall_addr",  m_address,     32'h0000_0200);
            chk("stall_mrd",   m_read,        1'b1);
            chk("stall_fwait", f_waitrequest, 1'b1);
            chk("stall_dwait", d_waitrequest, 1'b1);
            tick();
        end
        m_waitrequest = 1'b0;
        m_readdata    = 32'hCAFE_F00D;
        sample();
        chk("stall_done_grant", grant,         2'b10);
        chk("stall_done_dwait", d_waitrequest, 1'b0);
        chk("stall_done_rdata", d_readdata,    32'hCAFE_F00D);
        chk("stall_done_fwait", f_waitrequest, 1'b1);
        tick();
        d_read = 1'b0;
        sample();
        chk("stall_next_grant", grant,     2'b01);
        chk("stall_next_addr",  m_address, 32'h0000_0300);
        tick();
        f_read = 1'b0;
        sample();
        chk("stall_end_grant", grant, 2'b00);

        // ---------------- reset during a stalled data write ----------------
        // last completion was fetch, so without reset a tie would go to data.
        d_write       = 1'b1;
        d_address     = 32'h0000_0008;
        d_writedata   = 32'h5555_AAAA;
        m_waitrequest = 1'b1;
        tick();
        sample();
        chk("rst_pre_grant", grant,   2'b10);
        chk("rst_pre_mwr",   m_write, 1'b1);
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        d_write       = 1'b0;
        d_read        = 1'b1;
        f_read        = 1'b1;
        f_address     = 32'h0000_0400;
        m_waitrequest = 1'b0;
        sample();
        chk("rst_post_grant", grant,         2'b00);
        chk("rst_post_mwr",   m_write,       1'b0);
        chk("rst_post_dwait", d_waitrequest, 1'b1);
        tick();
        sample();
        chk("rst_tie_grant", grant, 2'b01);
        tick();
        // fetch completed; data now owns the port with read and write both raised
        f_read  = 1'b0;
        d_write = 1'b1;
        sample();
        chk("rw_grant", grant,   2'b10);
        chk("rw_mwr",   m_write, 1'b1);
        chk("rw_mrd",   m_read,  1'b0);
        tick();
        d_read  = 1'b0;
        d_write = 1'b0;
        sample();
        chk("rw_end_grant", grant, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
